// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data RAM between two masters:
//     port 0 - CPU data port
//     port 1 - debug / loader master (UART loader, test DMA)
//   The grant is decided combinationally every cycle. The granted master drives the
//   RAM in the same cycle, and read data is registered into a one-cycle response.
//   In priority mode (RR_MODE=0) the CPU normally wins. An aging counter forces port 1
//   through once it has waited MAX_WAIT cycles. RR_MODE=1 alternates between the ports
//   whenever both request.
// Ports
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   mN_req/we/addr/wdata        master N request, write flag, word address, write data
//   mN_gnt                      master N access performed this cycle
//   mN_rvalid/rdata             read response, valid for one cycle after a read grant
//   mem_we/re/addr/wdata        RAM control, address and write data
//   mem_rdata                   RAM read data, valid in the same cycle as mem_re
//   starve_cnt                  number of cycles port 1 has been waiting (debug)
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int RR_MODE  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        starve_cnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Per-port views of the request signals, so that the response path can be generated per port.
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  assign req      = {m1_req, m0_req};
  assign we       = {m1_we, m0_we};
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign wdata[0] = m0_wdata;
  assign wdata[1] = m1_wdata;

  logic [7:0]        starve_cnt_reg;
  logic [7:0]        starve_cnt_next;
  logic              last_grant_reg;   // 0: port 0 was granted last, 1: port 1 was granted last
  logic [ADDR_W-1:0] addr_reg;         // last granted address, held on the RAM bus when idle
  logic [DATA_W-1:0] wdata_reg;
  logic              rvalid_reg [2];
  logic [DATA_W-1:0] rdata_reg  [2];

  logic any_gnt;
  logic sel;

  // Grant decision. Reset masks every grant, so a request in flight at reset is dropped.
  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      if (RR_MODE != 0) begin
        if (req == 2'b11) begin
          if (last_grant_reg) gnt = 2'b01;
          else                gnt = 2'b10;
        end else begin
          gnt = req;
        end
      end else begin
        if (req[1] && (starve_cnt_reg == MAX_WAIT_C)) gnt = 2'b10;
        else if (req[0])                              gnt = 2'b01;
        else if (req[1])                              gnt = 2'b10;
      end
    end
  end

  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  assign mem_we    = any_gnt & we[sel];
  assign mem_re    = any_gnt & ~we[sel];
  assign mem_addr  = any_gnt ? addr[sel]  : addr_reg;
  assign mem_wdata = any_gnt ? wdata[sel] : wdata_reg;

  // Aging counter: counts consecutive cycles in which port 1 asks and is refused.
  always_comb begin
    starve_cnt_next = 8'd0;
    if (req[1] && !gnt[1]) begin
      if (starve_cnt_reg == MAX_WAIT_C) starve_cnt_next = starve_cnt_reg;
      else                              starve_cnt_next = starve_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_reg <= 8'd0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (any_gnt) begin
        last_grant_reg <= sel;
        addr_reg       <= addr[sel];
        wdata_reg      <= wdata[sel];
      end
    end
  end

  // Read response per port: capture RAM data at the end of the grant cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge CLK) begin
        if (RST) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= gnt[gi] & ~we[gi];
          if (gnt[gi] && !we[gi]) rdata_reg[gi] <= mem_rdata;
        end
      end
    end
  endgenerate

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  // A response that would land in a reset cycle is suppressed.
  assign m0_rvalid  = rvalid_reg[0] & ~RST;
  assign m1_rvalid  = rvalid_reg[1] & ~RST;
  assign m0_rdata   = rdata_reg[0];
  assign m1_rdata   = rdata_reg[1];
  assign starve_cnt = starve_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. Two instances are driven by the same masters:
//   u_prio (RR_MODE=0, MAX_WAIT=4) backed by a RAM model and fully scoreboarded, and
//   u_rr (RR_MODE=1), whose grants are compared against a round-robin reference.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_mem_re;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic [7:0]    a_starve;
  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_re;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [7:0]    b_starve;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .RR_MODE(0)) u_prio (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .starve_cnt(a_starve));

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .RR_MODE(1)) u_rr (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .starve_cnt(b_starve));

  // RAM behind the priority instance: asynchronous read, write at the rising edge.
  logic [DW-1:0] ram [1<<AW];
  assign a_mem_rdata = ram[a_mem_addr];
  always @(posedge CLK) if (a_mem_we === 1'b1) ram[a_mem_addr] <= a_mem_wdata;
  assign b_mem_rdata = {{(DW-AW){1'b0}}, b_mem_addr};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state.
  logic          armed = 1'b0;
  int            waited;
  logic          rr_last;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] model_mem [1<<AW];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  // Values seen by the checker, used by the masters to follow the handshake.
  logic          s_g0 = 0, s_g1 = 0, s_b1 = 0, s_rv0 = 0, s_rv1 = 0;
  logic [DW-1:0] s_rd0 = '0;

  // Checker: predicts grant, RAM bus and wait count; pushes expected read data.
  always @(negedge CLK) begin
    int eg, eb;
    logic          e_we;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd;
    logic [43:0]   e_bus;
    if (armed) begin
      if (RST)                         eg = -1;
      else if (m1_req && waited == MW) eg = 1;
      else if (m0_req)                 eg = 0;
      else if (m1_req)                 eg = 1;
      else                             eg = -1;
      chk("prio_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(eg == 0 ? 2'b01 : (eg == 1 ? 2'b10 : 2'b00)));
      if (eg >= 0) begin
        e_we = (eg == 1) ? m1_we : m0_we;
        e_ad = (eg == 1) ? m1_addr : m0_addr;
        e_wd = (eg == 1) ? m1_wdata : m0_wdata;
        e_bus = {e_we, ~e_we, e_ad, e_wd};
        last_addr = e_ad;
        last_wdata = e_wd;
        if (e_we)         model_mem[e_ad] = e_wd;
        else if (eg == 0) q0.push_back(model_mem[e_ad]);
        else              q1.push_back(model_mem[e_ad]);
      end else begin
        e_bus = {1'b0, 1'b0, last_addr, last_wdata};
      end
      chk("mem_bus", 64'({a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata}), 64'(e_bus));
      chk("starve_cnt", 64'(a_starve), 64'(waited));
      if (m1_req && eg != 1) waited = (waited >= MW) ? MW : waited + 1;
      else                   waited = 0;

      if (RST)                   eb = -1;
      else if (m0_req && m1_req) eb = rr_last ? 0 : 1;
      else if (m0_req)           eb = 0;
      else if (m1_req)           eb = 1;
      else                       eb = -1;
      chk("rr_gnt", 64'({b_m1_gnt, b_m0_gnt}), 64'(eb == 0 ? 2'b01 : (eb == 1 ? 2'b10 : 2'b00)));
      if (eb >= 0) rr_last = (eb == 1);

      if (RST) begin
        waited = 0;
        rr_last = 1'b1;
        last_addr = '0;
        last_wdata = '0;
      end
    end
    s_g0 = a_m0_gnt; s_g1 = a_m1_gnt; s_b1 = b_m1_gnt;
    s_rv0 = a_m0_rvalid; s_rv1 = a_m1_rvalid; s_rd0 = a_m0_rdata;
  end

  // Monitor: pops the scoreboard whenever a read response is presented.
  always @(negedge CLK) begin
    logic [DW-1:0] e;
    if (armed) begin
      if (RST) begin
        chk("rvalid_in_reset", 64'({a_m1_rvalid, a_m0_rvalid}), 64'(2'b00));
        q0.delete();
        q1.delete();
      end else begin
        if (a_m0_rvalid !== 1'b0) begin
          if (q0.size() == 0) chk("m0_unexpected_rvalid", 64'(a_m0_rvalid), 64'(1'b0));
          else begin e = q0.pop_front(); chk("m0_rdata", 64'(a_m0_rdata), 64'(e)); end
        end
        if (a_m1_rvalid !== 1'b0) begin
          if (q1.size() == 0) chk("m1_unexpected_rvalid", 64'(a_m1_rvalid), 64'(1'b0));
          else begin e = q1.pop_front(); chk("m1_rdata", 64'(a_m1_rdata), 64'(e)); end
        end
      end
    end
  end

  // Masters: each holds its pending transaction until it sees its grant.
  logic          p_req  [2];
  logic          p_we   [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];

  task automatic set_txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
  endtask

  task automatic cycle();
    m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_data[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_data[1];
    @(posedge CLK); #1;
    if (s_g0) p_req[0] = 1'b0;
    if (s_g1) p_req[1] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((p_req[0] || p_req[1]) && n < 20) begin cycle(); n++; end
    chk(name, 64'({p_req[1], p_req[0]}), 64'(2'b00));
    p_req[0] = 1'b0; p_req[1] = 1'b0;
  endtask

  logic [11:0] h_prio, h_rr;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; model_mem[i] = '0; end
    waited = 0; rr_last = 1'b1; last_addr = '0; last_wdata = '0;
    for (int p = 0; p < 2; p++) begin p_req[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_data[p] = '0; end
    RST = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    @(posedge CLK); #1;
    armed = 1'b1;

    // Reset held with both masters requesting writes.
    set_txn(0, 1'b1, 10'h005, 32'h1111_1111);
    set_txn(1, 1'b1, 10'h006, 32'h2222_2222);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("reset_gnt_rvalid", 64'({s_g0, s_g1, s_rv0, s_rv1}), 64'(4'b0000));
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    RST = 1'b0;
    cycle();

    // Both masters continuously requesting for 12 cycles.
    for (int c = 0; c < 12; c++) begin
      if (!p_req[0]) set_txn(0, 1'b0, AW'(c), '0);
      if (!p_req[1]) set_txn(1, 1'b0, AW'(c + 16), '0);
      cycle();
      h_prio[c] = s_g1;
      h_rr[c] = s_b1;
    end
    chk("aging_m1_grant_cycles", 64'(h_prio), 64'(12'b0010_0001_0000));
    chk("rr_alternation", 64'(h_rr[5:0]), 64'(6'b101010));
    wait_idle("aging_drain");

    // CPU alone: write then read back.
    set_txn(0, 1'b1, 10'h010, 32'hDEAD_BEEF);
    wait_idle("cpu_write");
    set_txn(0, 1'b0, 10'h010, '0);
    wait_idle("cpu_read");
    cycle();
    chk("cpu_readback", 64'({s_rv0, s_rd0}), 64'({1'b1, 32'hDEAD_BEEF}));

    // Same-address write race, then read.
    set_txn(0, 1'b1, 10'h020, 32'h1);
    set_txn(1, 1'b1, 10'h020, 32'h2);
    wait_idle("race_writes");
    set_txn(0, 1'b0, 10'h020, '0);
    wait_idle("race_read");
    cycle();
    chk("race_readback", 64'({s_rv0, s_rd0}), 64'({1'b1, 32'h2}));

    // Reset right after a port-1 read grant.
    set_txn(1, 1'b0, 10'h010, '0);
    wait_idle("m1_read");
    RST = 1'b1;
    set_txn(0, 1'b0, 10'h001, '0);
    set_txn(1, 1'b1, 10'h002, 32'h55);
    cycle();
    chk("reset_mid_read_rvalid", 64'(s_rv1), 64'(1'b0));
    cycle();
    chk("reset_no_grant", 64'({s_g0, s_g1}), 64'(2'b00));
    RST = 1'b0;
    wait_idle("after_reset_drain");

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 3) != 0)
          set_txn(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      cycle();
    end
    RST = 1'b0;
    wait_idle("random_drain");
    cycle();
    cycle();
    chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
